midi_out_tx: RTL

Downstream MIDI-out serializer for the synth controller. Pulls bytes from the patch-dump generator using a falling-edge request strobe on midi_out_ready, and serializes them as 31250-baud 8N1 onto midi_txd. A stream ends when the generator returns the 0xFF end marker. Between streams it also forwards single MIDI-thru bytes through a valid/ready port.

---
 rtl/midi_tx_pkg.sv | 26 ++
 rtl/midi_uart_tx_core.sv | 68 ++++++
 rtl/midi_out_tx.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/midi_tx_pkg.sv
// Shared types and constants for the MIDI-out transmitter.
package midi_tx_pkg;

  // Fetch/transmit sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETTLE,
    S_LOAD,
    S_SHIFT
  } state_t;

  // MIDI system-exclusive framing bytes and the generator's end-of-stream marker.
  localparam logic [7:0] MIDI_SOX   = 8'hF0;
  localparam logic [7:0] MIDI_EOX   = 8'hF7;
  localparam logic [7:0] STREAM_END = 8'hFF;

  // 8N1 frame: start bit, eight data bits, stop bit.
  localparam int FRAME_BITS = 10;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int calc_bit_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/midi_uart_tx_core.sv
// 8N1 serializer: baud divider plus a 10-bit frame shift register.
// A one-cycle i_load starts a frame whose start bit begins on the next cycle.
module midi_uart_tx_core
  import midi_tx_pkg::*;
#(
  parameter int BIT_DIV = 1600
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       i_load,
  input  logic [7:0] i_data,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_done
);

  localparam int                   DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(BIT_DIV - 1);
  localparam logic [3:0]           IDX_LAST = 4'(FRAME_BITS - 1);

  logic [DIV_W-1:0]      r_div;
  logic [3:0]            r_idx;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_busy;

  logic w_bit_end;
  logic w_frame_end;

  assign w_bit_end   = (r_div == DIV_LAST);
  assign w_frame_end = r_busy && w_bit_end && (r_idx == IDX_LAST);

  // Bit timing and shifting; the line bit is always r_shift[0].
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      // NOTE: the shift register resets to all ones so the line idles high the instant reset asserts, truncating any frame in flight.
      r_shift <= '1;
      r_div   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else if (i_load) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_shift <= {1'b1, i_data, 1'b0};
      r_div   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_div <= '0;
        if (r_idx == IDX_LAST) begin
          r_idx   <= '0;
          r_busy  <= 1'b0;
          r_shift <= '1;
        end else begin
          r_idx   <= r_idx + 4'd1;
          r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_txd  = r_shift[0];
  assign o_busy = r_busy;
  // Decoded from flops only: high during the last cycle of the stop bit.
  assign o_done = w_frame_end;

endmodule

// File: rtl/midi_out_tx.sv
// MIDI-out serializer: pulls patch-dump bytes from the generator with a
// low-going request strobe, ends the stream on 0xFF or the byte limit, and
// forwards single MIDI-thru bytes while no stream is running.
module midi_out_tx
  import midi_tx_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 31250,
  parameter int REQ_LOW_CYC = 4,
  parameter int SETTLE_CYC  = 2,
  parameter int MAX_STREAM  = 240
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       patch_send,
  input  logic [7:0] midi_out_data,
  output logic       midi_out_ready,
  input  logic       thru_valid,
  input  logic [7:0] thru_data,
  output logic       thru_ready,
  output logic       midi_txd,
  output logic       tx_busy,
  output logic       stream_active,
  output logic       stream_err,
  output logic       byte_sent
);

  localparam int         BIT_DIV     = calc_bit_div(CLK_HZ, BAUD);
  localparam logic [7:0] REQ_LAST    = 8'(REQ_LOW_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] STREAM_MAX  = 8'(MAX_STREAM);

  state_t     r_state;
  logic [7:0] r_wait;
  logic [7:0] r_stream_cnt;
  logic       r_ready;
  logic       r_active;
  logic       r_err;

  logic       w_thru_accept;
  logic       w_fetch_ok;
  logic       w_load;
  logic [7:0] w_load_data;
  logic       w_tx_done;
  logic       w_tx_busy;
  logic       w_txd;

  // A thru byte is taken only from IDLE and only when no stream start is
  // pending; the accept is decoded from the state flop so the handshake and
  // the frame load happen in the same cycle.
  assign w_thru_accept = (r_state == S_IDLE) && !patch_send && thru_valid;

  // A fetched byte is sent unless it is the end marker or the limit is hit.
  assign w_fetch_ok = (r_state == S_LOAD) && (midi_out_data != STREAM_END) &&
                      (r_stream_cnt != STREAM_MAX);

  assign w_load      = w_thru_accept || w_fetch_ok;
  assign w_load_data = w_thru_accept ? thru_data : midi_out_data;

  midi_uart_tx_core #(
    .BIT_DIV (BIT_DIV)
  ) u_core (
    .reg_clk     (reg_clk),
    .reset_reg_N (reset_reg_N),
    .i_load      (w_load),
    .i_data      (w_load_data),
    .o_txd       (w_txd),
    .o_busy      (w_tx_busy),
    .o_done      (w_tx_done)
  );

  // Fetch sequencer: request strobe, settle wait, sample, then transmit.
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      r_state      <= S_IDLE;
      r_wait       <= '0;
      r_stream_cnt <= '0;
      r_ready      <= 1'b1;
      r_active     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (patch_send) begin
            r_active     <= 1'b1;
            r_err        <= 1'b0;
            r_stream_cnt <= '0;
            r_wait       <= '0;
            r_ready      <= 1'b0;
            r_state      <= S_REQ;
          end else if (thru_valid) begin
            r_state <= S_SHIFT;
          end
        end

        S_REQ: begin
          if (r_wait == REQ_LAST) begin
            r_wait  <= '0;
            r_ready <= 1'b1;
            r_state <= S_SETTLE;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end

        S_SETTLE: begin
          if (r_wait == SETTLE_LAST) begin
            r_wait  <= '0;
            r_state <= S_LOAD;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end

        S_LOAD: begin
          if (midi_out_data == STREAM_END) begin
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_stream_cnt == STREAM_MAX) begin
            r_err    <= 1'b1;
            r_active <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_stream_cnt <= r_stream_cnt + 8'd1;
            r_state      <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_tx_done) begin
            if (r_active) begin
              r_ready <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign midi_out_ready = r_ready;
  assign thru_ready     = w_thru_accept;
  assign midi_txd       = w_txd;
  assign tx_busy        = w_tx_busy;
  assign stream_active  = r_active;
  assign stream_err     = r_err;
  assign byte_sent      = w_tx_done;

endmodule
